// File: rtl/tile_render_pipe.sv
// rtl/tile_render_pipe.sv - three-stage tile renderer: scrolled map lookup, texel fetch, keyed RGB output
module tile_render_pipe #(
    parameter int                     TILE_LOG2       = 4,
    parameter int                     NUM_TILES       = 4,
    parameter int                     MAP_COLS        = 40,
    parameter int                     MAP_ROWS        = 30,
    parameter int                     COLOR_W         = 4,
    parameter logic [3*COLOR_W-1:0]   TRANSPARENT_KEY = 12'hF0F,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR        = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic                   pix_valid,
    input  logic                   frame_start,
    input  logic [9:0]             scroll_x_in,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [15:0]            cfg_addr,
    input  logic [3*COLOR_W-1:0]   cfg_data,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic                   rgb_valid,
    output logic                   is_bg
);

    localparam int PIX_W     = 3 * COLOR_W;
    localparam int TID_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int ME_W      = TID_W + 1;
    localparam int TILE      = 1 << TILE_LOG2;
    localparam int MAP_PX    = MAP_COLS * TILE;
    localparam int MAP_PY    = MAP_ROWS * TILE;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int MAP_AW    = $clog2(MAP_DEPTH);
    localparam int TEX_AW    = TID_W + 2 * TILE_LOG2;
    localparam int TEX_DEPTH = NUM_TILES * TILE * TILE;

    logic [ME_W-1:0]  map_ram [MAP_DEPTH];
    logic [PIX_W-1:0] tex_ram [TEX_DEPTH];

    logic [9:0]            scroll_q;
    logic                  s0_valid_q;
    logic [15:0]           s0_map_addr_q;
    logic [TILE_LOG2-1:0]  s0_row_q;
    logic [TILE_LOG2-1:0]  s0_col_q;
    logic                  s0_oob_q;
    logic                  s1_valid_q;
    logic [TEX_AW-1:0]     s1_tex_addr_q;
    logic                  s1_oob_q;
    logic [PIX_W-1:0]      rgb_q;
    logic                  rgb_valid_q;
    logic                  is_bg_q;

    logic                  scroll_load;
    logic [10:0]           xe_sum;
    logic [10:0]           xe;
    logic [15:0]           map_addr_d;
    logic                  oob0_d;
    logic                  map_hit;
    logic [ME_W-1:0]       map_entry;
    logic [TID_W-1:0]      tile_id;
    logic                  hflip;
    logic [TILE_LOG2-1:0]  col_f;
    logic [TEX_AW-1:0]     tex_addr_d;
    logic                  oob1_d;
    logic [PIX_W-1:0]      texel;
    logic [PIX_W-1:0]      rgb_d;
    logic                  rgb_valid_d;
    logic                  is_bg_d;

    // RAMs have no reset; reads below sample the pre-write contents on a same-edge collision
    always_ff @(posedge clk) begin
        if (cfg_we && !cfg_sel && (32'(cfg_addr) < MAP_DEPTH))
            map_ram[cfg_addr[MAP_AW-1:0]] <= cfg_data[ME_W-1:0];
        if (cfg_we && cfg_sel && (32'(cfg_addr) < TEX_DEPTH))
            tex_ram[cfg_addr[TEX_AW-1:0]] <= cfg_data;
    end

    always_comb begin
        scroll_load = frame_start && (32'(scroll_x_in) < MAP_PX);
        xe_sum      = {1'b0, pix_x} + {1'b0, scroll_q};
        xe          = xe_sum;
        if (32'(xe_sum) >= MAP_PX)
            xe = xe_sum - 11'(MAP_PX);
        map_addr_d  = 16'(32'(pix_y >> TILE_LOG2) * MAP_COLS + 32'(xe >> TILE_LOG2));
        oob0_d      = 32'(pix_y) >= MAP_PY;
    end

    // Rows past the map bottom produce addresses beyond the RAM; those are already oob
    always_comb begin
        map_hit    = 32'(s0_map_addr_q) < MAP_DEPTH;
        map_entry  = map_hit ? map_ram[s0_map_addr_q[MAP_AW-1:0]] : '0;
        tile_id    = map_entry[TID_W-1:0];
        hflip      = map_entry[TID_W];
        col_f      = hflip ? ~s0_col_q : s0_col_q;
        tex_addr_d = {tile_id, s0_row_q, col_f};
        oob1_d     = s0_oob_q || !map_hit || (32'(tile_id) >= NUM_TILES);
    end

    always_comb begin
        texel       = (32'(s1_tex_addr_q) < TEX_DEPTH) ? tex_ram[s1_tex_addr_q] : '0;
        rgb_d       = '0;
        rgb_valid_d = 1'b0;
        is_bg_d     = 1'b0;
        if (s1_valid_q) begin
            rgb_valid_d = 1'b1;
            if (s1_oob_q || (texel == TRANSPARENT_KEY)) begin
                rgb_d   = BG_COLOR;
                is_bg_d = 1'b1;
            end else begin
                rgb_d   = texel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_q      <= '0;
            s0_valid_q    <= 1'b0;
            s0_map_addr_q <= '0;
            s0_row_q      <= '0;
            s0_col_q      <= '0;
            s0_oob_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_tex_addr_q <= '0;
            s1_oob_q      <= 1'b0;
            rgb_q         <= '0;
            rgb_valid_q   <= 1'b0;
            is_bg_q       <= 1'b0;
        end else begin
            if (scroll_load)
                scroll_q <= scroll_x_in;
            s0_valid_q    <= pix_valid;
            s0_map_addr_q <= map_addr_d;
            s0_row_q      <= pix_y[TILE_LOG2-1:0];
            s0_col_q      <= xe[TILE_LOG2-1:0];
            s0_oob_q      <= oob0_d;
            s1_valid_q    <= s0_valid_q;
            s1_tex_addr_q <= tex_addr_d;
            s1_oob_q      <= oob1_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
            is_bg_q       <= is_bg_d;
        end
    end

    assign R         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign G         = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign B         = rgb_q[COLOR_W-1 -: COLOR_W];
    assign rgb_valid = rgb_valid_q;
    assign is_bg     = is_bg_q;

endmodule

// File: tb/tb_tile_render_pipe.sv
// tb/tb_tile_render_pipe.sv - directed vector bench for tile_render_pipe
module tb_tile_render_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        frame_start;
    logic [9:0]  scroll_x_in;
    logic        cfg_we;
    logic        cfg_sel;
    logic [15:0] cfg_addr;
    logic [11:0] cfg_data;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        rgb_valid;
    logic        is_bg;

    always #5 clk = ~clk;

    tile_render_pipe #(.NUM_TILES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .scroll_x_in (scroll_x_in),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .R           (R),
        .G           (G),
        .B           (B),
        .rgb_valid   (rgb_valid),
        .is_bg       (is_bg)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [11:0] rgb;
        logic        ev;
        logic        bg;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic sel, input logic [15:0] addr, input logic [11:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic frame(input logic [9:0] s);
        frame_start = 1'b1;
        scroll_x_in = s;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic v,
                         output logic [11:0] rgb, output logic rv, output logic bg);
        pix_x     = x;
        pix_y     = y;
        pix_valid = v;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rgb = {R, G, B};
        rv  = rgb_valid;
        bg  = is_bg;
    endtask

    task automatic check_pix(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic [11:0] exp_rgb, input logic exp_bg);
        logic [11:0] rgb;
        logic        rv;
        logic        bg;
        pixel(x, y, 1'b1, rgb, rv, bg);
        check({name, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        check({name, "_valid"}, 32'(rv), 32'd1);
        check({name, "_bg"}, 32'(bg), 32'(exp_bg));
    endtask

    initial begin
        logic [11:0] rgb;
        logic        rv;
        logic        bg;

        vecs[0]  = '{10'd0,   10'd0,   1'b1, 12'hABC, 1'b1, 1'b0};
        vecs[1]  = '{10'd15,  10'd0,   1'b1, 12'h123, 1'b1, 1'b0};
        vecs[2]  = '{10'd16,  10'd0,   1'b1, 12'h456, 1'b1, 1'b0};
        vecs[3]  = '{10'd32,  10'd0,   1'b1, 12'h123, 1'b1, 1'b0};
        vecs[4]  = '{10'd47,  10'd0,   1'b1, 12'hABC, 1'b1, 1'b0};
        vecs[5]  = '{10'd1,   10'd0,   1'b1, 12'h000, 1'b1, 1'b1};
        vecs[6]  = '{10'd48,  10'd0,   1'b1, 12'h000, 1'b1, 1'b1};
        vecs[7]  = '{10'd0,   10'd480, 1'b1, 12'h000, 1'b1, 1'b1};
        vecs[8]  = '{10'd3,   10'd21,  1'b1, 12'h5A3, 1'b1, 1'b0};
        vecs[9]  = '{10'd639, 10'd479, 1'b1, 12'hE21, 1'b1, 1'b0};
        vecs[10] = '{10'd0,   10'd0,   1'b0, 12'h000, 1'b0, 1'b0};

        rst_n       = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        scroll_x_in = '0;
        cfg_we      = 1'b0;
        cfg_sel     = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb", 32'({R, G, B}), 32'h0);
        check("reset_valid", 32'(rgb_valid), 32'd0);
        check("reset_bg", 32'(is_bg), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        cfg_write(1'b1, 16'd256, 12'hABC);
        cfg_write(1'b1, 16'd271, 12'h123);
        cfg_write(1'b1, 16'd257, 12'hF0F);
        cfg_write(1'b1, 16'd339, 12'h5A3);
        cfg_write(1'b1, 16'd512, 12'h456);
        cfg_write(1'b1, 16'd767, 12'hE21);
        cfg_write(1'b0, 16'd0,    12'h001);
        cfg_write(1'b0, 16'd1,    12'h002);
        cfg_write(1'b0, 16'd2,    12'h005);
        cfg_write(1'b0, 16'd3,    12'h003);
        cfg_write(1'b0, 16'd40,   12'h001);
        cfg_write(1'b0, 16'd1199, 12'h002);
        cfg_write(1'b0, 16'd2048, 12'h002);
        cfg_write(1'b1, 16'd1280, 12'h999);
        cfg_write(1'b1, 16'd768,  12'h999);

        for (int i = 0; i < 11; i++) begin
            pixel(vecs[i].x, vecs[i].y, vecs[i].v, rgb, rv, bg);
            check($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].rgb));
            check($sformatf("vec%0d_valid", i), 32'(rv), 32'(vecs[i].ev));
            check($sformatf("vec%0d_bg", i), 32'(bg), 32'(vecs[i].bg));
        end

        frame(10'd16);
        check_pix("scroll16", 10'd0, 10'd0, 12'h456, 1'b0);
        scroll_x_in = 10'd32;
        @(posedge clk); #1;
        check_pix("scroll_nofs", 10'd0, 10'd0, 12'h456, 1'b0);
        frame(10'd640);
        check_pix("scroll_oor", 10'd0, 10'd0, 12'h456, 1'b0);
        frame(10'd639);
        check_pix("scroll_wrap", 10'd1, 10'd0, 12'hABC, 1'b0);

        frame(10'd0);
        pix_x     = 10'd0;
        pix_y     = 10'd0;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_addr = 16'd256;
        cfg_data = 12'h777;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        check("collide_old_rgb", 32'({R, G, B}), 32'hABC);
        check("collide_old_valid", 32'(rgb_valid), 32'd1);
        check_pix("collide_new", 10'd0, 10'd0, 12'h777, 1'b0);

        frame(10'd16);
        pix_y     = 10'd0;
        pix_x     = 10'd0;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_x = 10'd16;
        @(posedge clk); #1;
        pix_x = 10'd31;
        @(posedge clk); #1;
        check("stream0_rgb", 32'({R, G, B}), 32'h456);
        check("stream0_valid", 32'(rgb_valid), 32'd1);
        pix_x = 10'd32;
        @(posedge clk); #1;
        check("stream1_rgb", 32'({R, G, B}), 32'h123);
        check("stream1_valid", 32'(rgb_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rgb", 32'({R, G, B}), 32'h0);
        check("midrst_valid", 32'(rgb_valid), 32'd0);
        check("midrst_bg", 32'(is_bg), 32'd0);
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle_valid", 32'(rgb_valid), 32'd0);

        pix_x     = 10'd0;
        pix_y     = 10'd0;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        check("lat1_valid", 32'(rgb_valid), 32'd0);
        @(posedge clk); #1;
        check("lat2_valid", 32'(rgb_valid), 32'd0);
        @(posedge clk); #1;
        check("lat3_valid", 32'(rgb_valid), 32'd1);
        check("lat3_rgb", 32'({R, G, B}), 32'h777);
        @(posedge clk); #1;
        check("lat4_valid", 32'(rgb_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_render_pipe.md
Name: tile_render_pipe

Overview:
- Pipelined, parametrised successor to the fixed 16x16 combinational wall-tile ROM.
- Holds a writable texel RAM of NUM_TILES square tiles and a writable tile map (tile id plus horizontal-flip bit per cell).
- Converts VGA pixel coordinates into registered RGB with fixed latency, per-frame horizontal scroll, transparency keying and out-of-map background fill.
- Sits between the VGA timing generator and the sprite/overlay mixer.

Parameters:
TILE_LOG2, 4, tile edge = 2**TILE_LOG2 pixels (default 16)
NUM_TILES, 4, number of tiles in texel RAM; TID_W = max(1, clog2(NUM_TILES))
MAP_COLS, 40, tile map width in tiles
MAP_ROWS, 30, tile map height in tiles
COLOR_W, 4, bits per colour channel; texel width PIX_W = 3*COLOR_W
TRANSPARENT_KEY, 12'hF0F, texel value treated as transparent
BG_COLOR, 12'h000, colour for transparent or out-of-map pixels

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
pix_valid  in  1  visible-area pixel strobe
frame_start  in  1  one-cycle pulse at start of frame
scroll_x_in  in  10  requested horizontal scroll, in pixels
cfg_we  in  1  configuration write strobe
cfg_sel  in  1  0 = tile map, 1 = texel RAM
cfg_addr  in  16  map: row*MAP_COLS+col; texel: tile*TILE^2 + row*TILE + col
cfg_data  in  PIX_W  texel value, or map entry in bits [TID_W:0] = {hflip, tile_id}
R  out  COLOR_W  red
G  out  COLOR_W  green
B  out  COLOR_W  blue
rgb_valid  out  1  output pixel valid
is_bg  out  1  pixel was filled with BG_COLOR

Behaviour:
- Reset: R, G, B, rgb_valid and is_bg are 0 immediately (asynchronous). All pipeline valid bits clear. Scroll register = 0. RAM contents are not cleared.
- Scroll register: loads scroll_x_in only on a cycle with frame_start=1 and scroll_x_in < MAP_COLS*TILE; otherwise it holds. A scroll_x_in change without frame_start has no effect.
- Effective x: xe = pix_x + scroll. If xe >= MAP_COLS*TILE, subtract MAP_COLS*TILE (single wrap).
- Stage S0 (cycle n+1), registered:
  - map address = (pix_y>>TILE_LOG2)*MAP_COLS + (xe>>TILE_LOG2)
  - texel row/col = low TILE_LOG2 bits of pix_y and xe
  - oob = pix_y >= MAP_ROWS*TILE
  - valid
- Stage S1 (cycle n+2): synchronous map read gives {hflip, tile_id}. If hflip=1, col' = TILE-1-col. Texel address formed and registered. tile_id >= NUM_TILES forces oob.
- Stage S2 (cycle n+3): synchronous texel read, output registered.
  - if valid=0: R=G=B=0, rgb_valid=0, is_bg=0
  - if oob or texel==TRANSPARENT_KEY: {R,G,B}=BG_COLOR, is_bg=1, rgb_valid=1
  - otherwise {R,G,B}=texel, is_bg=0, rgb_valid=1
- Latency is exactly 3 cycles from pix_valid to rgb_valid. One pixel per cycle, no stalls, no backpressure.
- Config writes: always accepted in one cycle. Addresses out of range (map >= MAP_COLS*MAP_ROWS, texel >= NUM_TILES*TILE^2) are ignored. Map writes store only bits [TID_W:0].
- Read/write collision: write to the address being read in the same cycle returns old data (read-first). New data is visible on the next access.
- Reset mid-operation: in-flight pixels are discarded. After rst_n release, the first rgb_valid occurs 3 cycles after the first pix_valid.

Test Plan:
- Write texel addr 256 (tile 1, r0 c0) = 12'hABC; map[0] = 2'b01 (tile 1); pix (0,0) valid at cycle n -> cycle n+3: R=A, G=B, B=C, rgb_valid=1, is_bg=0.
- Map[0] = {hflip=1, tile 1}; texel 256+15 = 12'h123; pix (0,0) -> RGB 123. pix (15,0) -> ABC.
- Scroll: scroll_x_in=16 with frame_start; map[1] = tile 2 whose texel(0,0) = 12'h456; pix (0,0) -> 456. scroll_x_in=32 without frame_start -> still 456. Scroll=639, pix (1,0) -> wraps to map[0].
- pix (0,480) -> BG_COLOR, is_bg=1. Texel = 12'hF0F -> BG_COLOR, is_bg=1. Map entry tile_id=4 with NUM_TILES=4... use NUM_TILES=3 -> BG_COLOR.
- Texel write to 256 = 12'h777 in the same cycle as S2 reads 256 (old ABC) -> output ABC. Next read -> 777.
- Stream 4 valid pixels, assert rst_n low mid-stream -> outputs 0 within the same cycle. Release, drive pix_valid at cycle m -> rgb_valid first at m+3. Scroll reads back 0 (pix (0,0) -> map[0]).
